// File: rtl/data_sram_responder.sv
// -----------------------------------------------------------------------------
// data_sram_responder
//
// Memory-side responder for the core's data SRAM interface. The EX stage
// drives en/wen/addr/wdata; the MEM stage consumes rdata one cycle after the
// access is performed. A word-organised RAM with byte-lane writes sits behind
// an optional wait-state FSM that holds the pipeline with stallreq, so the
// core can be exercised against slower memory. Used in simulation and FPGA
// builds in place of the external data RAM.
//
// Ports:
//   clk              clock
//   rst              synchronous, active-high reset
//   data_sram_en     access request
//   data_sram_wen    byte write enables (4'b0000 = read)
//   data_sram_addr   byte address; [1:0] ignored, word index = [ADDR_W+1:2]
//   data_sram_wdata  write data
//   data_sram_rdata  registered read data (valid the cycle after the access)
//   stallreq         stall request to the pipeline stall controller
//   addr_err         one-cycle pulse after an out-of-range access
//
// Parameters:
//   ADDR_W       word-index width; depth = 2**ADDR_W 32-bit words
//   WAIT_CYCLES  stall cycles inserted per access (0..15)
//
// FSM states (only used when WAIT_CYCLES > 0):
//   state | meaning
//   IDLE  | no request pending; a new request raises stallreq and loads cnt
//   WAIT  | counting down the remaining stall cycles; inputs ignored
//   READY | stallreq low; the held request (if still asserted) is performed
// -----------------------------------------------------------------------------
module data_sram_responder #(
    parameter int ADDR_W      = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stallreq,
    output logic        addr_err
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam bit         HAS_WAIT = (WAIT_CYCLES > 0);
    // First stall cycle happens in IDLE, so the counter covers the rest.
    localparam logic [3:0] CNT_LOAD = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t             state;
    logic [3:0]         cnt;

    logic [31:0]        mem [DEPTH];

    logic [ADDR_W-1:0]  word_idx;
    logic               in_range;
    logic               do_access;
    logic               do_write;
    logic               do_read;
    logic               unused_addr_lsbs;

    assign word_idx         = data_sram_addr[ADDR_W+1:2];
    assign in_range         = (data_sram_addr[31:ADDR_W+2] == '0);
    assign unused_addr_lsbs = ^data_sram_addr[1:0];

    // Access strobe: every requested cycle without wait states, otherwise
    // only in READY. Reset suppresses it so a reset in READY cannot leave a
    // partial write behind.
    always_comb begin
        do_access = 1'b0;
        if (!rst) begin
            if (HAS_WAIT) begin
                do_access = (state == READY) && data_sram_en;
            end else begin
                do_access = data_sram_en;
            end
        end
    end

    assign do_write = do_access && in_range && (data_sram_wen != 4'b0000);
    assign do_read  = do_access && (data_sram_wen == 4'b0000);

    // stallreq must react in the same cycle the request appears, so it is a
    // decode of the current state and en rather than a registered output.
    always_comb begin
        stallreq = 1'b0;
        if (!rst && HAS_WAIT) begin
            stallreq = ((state == IDLE) && data_sram_en) || (state == WAIT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (HAS_WAIT && data_sram_en) begin
                        cnt   <= CNT_LOAD;
                        state <= (WAIT_CYCLES == 1) ? READY : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= READY;
                    end
                end
                READY: begin
                    // Single-shot: a request still held after READY is a new one.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // RAM array has no reset so it maps onto block RAM with byte enables.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wen[i]) begin
                    mem[word_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_sram_rdata <= 32'd0;
            addr_err        <= 1'b0;
        end else begin
            addr_err <= do_access && !in_range;
            if (do_read) begin
                data_sram_rdata <= in_range ? mem[word_idx] : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
`timescale 1ns/1ps
module tb_data_sram_responder;

    localparam int AW = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        en    [3];
    logic [3:0]  wen   [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        stall [3];
    logic        aerr  [3];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: word contents per instance, keyed by instance and index.
    bit   [31:0] ref_mem [longint];
    logic [31:0] exp_rd  [3];
    bit          stall0_seen = 1'b0;

    always #5 clk = ~clk;

    // Index 0: WAIT_CYCLES=0, index 1: WAIT_CYCLES=2, index 2: WAIT_CYCLES=3
    data_sram_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .data_sram_en(en[0]), .data_sram_wen(wen[0]),
        .data_sram_addr(addr[0]), .data_sram_wdata(wdata[0]),
        .data_sram_rdata(rdata[0]), .stallreq(stall[0]), .addr_err(aerr[0]));
    data_sram_responder #(.ADDR_W(AW), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst(rst), .data_sram_en(en[1]), .data_sram_wen(wen[1]),
        .data_sram_addr(addr[1]), .data_sram_wdata(wdata[1]),
        .data_sram_rdata(rdata[1]), .stallreq(stall[1]), .addr_err(aerr[1]));
    data_sram_responder #(.ADDR_W(AW), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst), .data_sram_en(en[2]), .data_sram_wen(wen[2]),
        .data_sram_addr(addr[2]), .data_sram_wdata(wdata[2]),
        .data_sram_rdata(rdata[2]), .stallreq(stall[2]), .addr_err(aerr[2]));

    always @(negedge clk) if (stall[0] === 1'b1) stall0_seen = 1'b1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int wait_of(input int k);
        return (k == 0) ? 0 : (k == 1) ? 2 : 3;
    endfunction

    // Present one request and hold it for W+1 cycles, then observe.
    task automatic access(input int k, input logic [3:0] w, input logic [31:0] a,
                          input logic [31:0] d, input bit withdraw,
                          output int scnt, output logic sready,
                          output logic [31:0] rd_early, output logic [31:0] rd,
                          output logic ae, output logic ae_next);
        int wc = wait_of(k);
        scnt = 0;
        @(posedge clk); #1;
        en[k] = 1'b1; wen[k] = w; addr[k] = a; wdata[k] = d;
        for (int c = 0; c < wc; c++) begin
            @(negedge clk);
            if (stall[k] === 1'b1) scnt++;
            @(posedge clk); #1;
        end
        if (withdraw) en[k] = 1'b0;
        @(negedge clk);
        sready = stall[k];
        if (stall[k] === 1'b1) scnt++;
        rd_early = rdata[k];
        @(posedge clk); #1;
        en[k] = 1'b0;
        @(negedge clk);
        rd = rdata[k];
        ae = aerr[k];
        @(negedge clk);
        ae_next = aerr[k];
    endtask

    task automatic model_access(input int k, input logic [3:0] w, input logic [31:0] a,
                                input logic [31:0] d, input bit withdraw, output logic eae);
        longint   key;
        bit [31:0] word;
        eae = 1'b0;
        if (withdraw) return;
        if (a[31:AW+2] != '0) begin
            eae = 1'b1;
            if (w == 4'h0) exp_rd[k] = 32'h0;
            return;
        end
        key = longint'(k) * (longint'(1) << AW) + longint'(a[AW+1:2]);
        if (w == 4'h0) begin
            exp_rd[k] = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
        end else begin
            word = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
            for (int i = 0; i < 4; i++) if (w[i]) word[8*i +: 8] = d[8*i +: 8];
            ref_mem[key] = word;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            en[k] = 1'b0; wen[k] = 4'h0; addr[k] = 32'h0; wdata[k] = 32'h0;
        end
        repeat (2) @(posedge clk);
        #1;
        en[2] = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (rdata[k] !== 32'h0) begin n_fail++; $display("FAIL reset_rdata inst=%0d got=%h exp=0", k, rdata[k]); end
            n_checks++;
            if (aerr[k] !== 1'b0) begin n_fail++; $display("FAIL reset_addr_err inst=%0d got=%b exp=0", k, aerr[k]); end
            n_checks++;
            if (stall[k] !== 1'b0) begin n_fail++; $display("FAIL reset_stall inst=%0d got=%b exp=0", k, stall[k]); end
        end
        @(posedge clk); #1;
        en[2] = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) exp_rd[k] = 32'h0;
    endtask

    task automatic test_write_read();
        int s; logic sr, ae, aen, eae; logic [31:0] rde, rd;
        for (int k = 0; k < 3; k++) begin
            access(k, 4'hF, 32'h10, 32'h12345678, 1'b0, s, sr, rde, rd, ae, aen);
            model_access(k, 4'hF, 32'h10, 32'h12345678, 1'b0, eae);
            n_checks++;
            if (s != wait_of(k)) begin n_fail++; $display("FAIL wr_stall_cycles inst=%0d got=%0d exp=%0d", k, s, wait_of(k)); end
            n_checks++;
            if (rd !== 32'h0) begin n_fail++; $display("FAIL wr_rdata_hold inst=%0d got=%h exp=0", k, rd); end
            access(k, 4'h0, 32'h10, 32'h0, 1'b0, s, sr, rde, rd, ae, aen);
            model_access(k, 4'h0, 32'h10, 32'h0, 1'b0, eae);
            n_checks++;
            if (rd !== 32'h12345678) begin n_fail++; $display("FAIL rd_full inst=%0d got=%h exp=12345678", k, rd); end
            n_checks++;
            if (sr !== 1'b0) begin n_fail++; $display("FAIL rd_ready_stall inst=%0d got=%b exp=0", k, sr); end
            access(k, 4'b0010, 32'h10, 32'h0000AB00, 1'b0, s, sr, rde, rd, ae, aen);
            model_access(k, 4'b0010, 32'h10, 32'h0000AB00, 1'b0, eae);
            access(k, 4'h0, 32'h10, 32'h0, 1'b0, s, sr, rde, rd, ae, aen);
            model_access(k, 4'h0, 32'h10, 32'h0, 1'b0, eae);
            n_checks++;
            if (rd !== 32'h1234AB78) begin n_fail++; $display("FAIL rd_partial inst=%0d got=%h exp=1234ab78", k, rd); end
        end
    endtask

    task automatic test_back_to_back_w0();
        int s; logic sr, ae, aen, eae; logic [31:0] rde, rd, r1, r2;
        access(0, 4'hF, 32'h14, 32'hA5A55A5A, 1'b0, s, sr, rde, rd, ae, aen);
        model_access(0, 4'hF, 32'h14, 32'hA5A55A5A, 1'b0, eae);
        @(posedge clk); #1;
        en[0] = 1'b1; wen[0] = 4'h0; addr[0] = 32'h10;
        @(posedge clk); #1;
        addr[0] = 32'h14;
        @(negedge clk);
        r1 = rdata[0];
        @(posedge clk); #1;
        en[0] = 1'b0;
        @(negedge clk);
        r2 = rdata[0];
        exp_rd[0] = 32'hA5A55A5A;
        n_checks++;
        if (r1 !== 32'h1234AB78) begin n_fail++; $display("FAIL b2b_first got=%h exp=1234ab78", r1); end
        n_checks++;
        if (r2 !== 32'hA5A55A5A) begin n_fail++; $display("FAIL b2b_second got=%h exp=a5a55a5a", r2); end
    endtask

    task automatic test_wait3_read();
        int s; logic sr, ae, aen, eae; logic [31:0] rde, rd, old;
        old = exp_rd[2];
        access(2, 4'h0, 32'h10, 32'h0, 1'b0, s, sr, rde, rd, ae, aen);
        model_access(2, 4'h0, 32'h10, 32'h0, 1'b0, eae);
        n_checks++;
        if (s != 3) begin n_fail++; $display("FAIL w3_stall_cycles got=%0d exp=3", s); end
        n_checks++;
        if (sr !== 1'b0) begin n_fail++; $display("FAIL w3_ready_stall got=%b exp=0", sr); end
        n_checks++;
        if (rde !== old) begin n_fail++; $display("FAIL w3_rdata_early got=%h exp=%h", rde, old); end
        n_checks++;
        if (rd !== 32'h1234AB78) begin n_fail++; $display("FAIL w3_rdata got=%h exp=1234ab78", rd); end
    endtask

    task automatic test_wait2_write();
        int s; logic sr, ae, aen, eae; logic [31:0] rde, rd;
        access(1, 4'hF, 32'h20, 32'hDEADBEEF, 1'b0, s, sr, rde, rd, ae, aen);
        model_access(1, 4'hF, 32'h20, 32'hDEADBEEF, 1'b0, eae);
        access(1, 4'h0, 32'h20, 32'h0, 1'b0, s, sr, rde, rd, ae, aen);
        model_access(1, 4'h0, 32'h20, 32'h0, 1'b0, eae);
        n_checks++;
        if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL w2_write got=%h exp=deadbeef", rd); end
        access(1, 4'hF, 32'h20, 32'h0BADF00D, 1'b1, s, sr, rde, rd, ae, aen);
        model_access(1, 4'hF, 32'h20, 32'h0BADF00D, 1'b1, eae);
        n_checks++;
        if (ae !== 1'b0) begin n_fail++; $display("FAIL w2_withdraw_addr_err got=%b exp=0", ae); end
        access(1, 4'h0, 32'h20, 32'h0, 1'b0, s, sr, rde, rd, ae, aen);
        model_access(1, 4'h0, 32'h20, 32'h0, 1'b0, eae);
        n_checks++;
        if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL w2_withdraw_unchanged got=%h exp=deadbeef", rd); end
    endtask

    task automatic test_back_to_back_wait();
        logic [5:0] pat; logic [31:0] r1, r2;
        r1 = 32'h0;
        @(posedge clk); #1;
        en[1] = 1'b1; wen[1] = 4'h0; addr[1] = 32'h20;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            pat[5-c] = stall[1];
            if (c == 3) r1 = rdata[1];
            @(posedge clk); #1;
            if (c == 2) addr[1] = 32'h10;
        end
        en[1] = 1'b0;
        @(negedge clk);
        r2 = rdata[1];
        exp_rd[1] = 32'h1234AB78;
        n_checks++;
        if (pat !== 6'b110110) begin n_fail++; $display("FAIL b2b_w2_stall_pattern got=%b exp=110110", pat); end
        n_checks++;
        if (r1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_w2_first got=%h exp=deadbeef", r1); end
        n_checks++;
        if (r2 !== 32'h1234AB78) begin n_fail++; $display("FAIL b2b_w2_second got=%h exp=1234ab78", r2); end
    endtask

    task automatic test_addr_err();
        int s; logic sr, ae, aen, eae; logic [31:0] rde, rd;
        for (int k = 0; k < 2; k++) begin
            access(k, 4'hF, 32'h0, 32'h11223344, 1'b0, s, sr, rde, rd, ae, aen);
            model_access(k, 4'hF, 32'h0, 32'h11223344, 1'b0, eae);
            access(k, 4'hF, 32'h0004_0000, 32'h55667788, 1'b0, s, sr, rde, rd, ae, aen);
            model_access(k, 4'hF, 32'h0004_0000, 32'h55667788, 1'b0, eae);
            n_checks++;
            if (ae !== 1'b1) begin n_fail++; $display("FAIL oor_wr_pulse inst=%0d got=%b exp=1", k, ae); end
            n_checks++;
            if (aen !== 1'b0) begin n_fail++; $display("FAIL oor_wr_pulse_end inst=%0d got=%b exp=0", k, aen); end
            access(k, 4'h0, 32'h0, 32'h0, 1'b0, s, sr, rde, rd, ae, aen);
            model_access(k, 4'h0, 32'h0, 32'h0, 1'b0, eae);
            n_checks++;
            if (rd !== 32'h11223344) begin n_fail++; $display("FAIL oor_wr_dropped inst=%0d got=%h exp=11223344", k, rd); end
            n_checks++;
            if (ae !== 1'b0) begin n_fail++; $display("FAIL inrange_no_err inst=%0d got=%b exp=0", k, ae); end
            access(k, 4'h0, 32'h0004_0000, 32'h0, 1'b0, s, sr, rde, rd, ae, aen);
            model_access(k, 4'h0, 32'h0004_0000, 32'h0, 1'b0, eae);
            n_checks++;
            if (rd !== 32'h0) begin n_fail++; $display("FAIL oor_rd_zero inst=%0d got=%h exp=0", k, rd); end
            n_checks++;
            if (ae !== 1'b1 || aen !== 1'b0) begin n_fail++; $display("FAIL oor_rd_pulse inst=%0d got=%b%b exp=10", k, ae, aen); end
        end
    endtask

    task automatic test_reset_mid_access();
        int s; logic sr, ae, aen, eae; logic [31:0] rde, rd; logic sw, srst;
        // Reset while in WAIT.
        @(posedge clk); #1;
        en[2] = 1'b1; wen[2] = 4'hF; addr[2] = 32'h10; wdata[2] = 32'hCAFEF00D;
        @(posedge clk); #1;
        @(negedge clk);
        sw = stall[2];
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        srst = stall[2];
        @(posedge clk); #1;
        rst = 1'b0; en[2] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (sw !== 1'b1) begin n_fail++; $display("FAIL rst_wait_stall_before got=%b exp=1", sw); end
        n_checks++;
        if (srst !== 1'b0) begin n_fail++; $display("FAIL rst_wait_stall_forced got=%b exp=0", srst); end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (rdata[k] !== 32'h0) begin n_fail++; $display("FAIL rst_wait_rdata inst=%0d got=%h exp=0", k, rdata[k]); end
            exp_rd[k] = 32'h0;
        end
        access(2, 4'h0, 32'h10, 32'h0, 1'b0, s, sr, rde, rd, ae, aen);
        model_access(2, 4'h0, 32'h10, 32'h0, 1'b0, eae);
        n_checks++;
        if (s != 3) begin n_fail++; $display("FAIL rst_wait_idle_after got=%0d exp=3", s); end
        n_checks++;
        if (rd !== 32'h1234AB78) begin n_fail++; $display("FAIL rst_wait_data got=%h exp=1234ab78", rd); end
        // Reset while in READY with the write still presented.
        @(posedge clk); #1;
        en[2] = 1'b1; wen[2] = 4'hF; addr[2] = 32'h10; wdata[2] = 32'hCAFEF00D;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(negedge clk);
        srst = stall[2];
        @(posedge clk); #1;
        rst = 1'b0; en[2] = 1'b0;
        for (int k = 0; k < 3; k++) exp_rd[k] = 32'h0;
        n_checks++;
        if (srst !== 1'b0) begin n_fail++; $display("FAIL rst_ready_stall got=%b exp=0", srst); end
        access(2, 4'h0, 32'h10, 32'h0, 1'b0, s, sr, rde, rd, ae, aen);
        model_access(2, 4'h0, 32'h10, 32'h0, 1'b0, eae);
        n_checks++;
        if (rde !== 32'h0) begin n_fail++; $display("FAIL rst_ready_rdata_cleared got=%h exp=0", rde); end
        n_checks++;
        if (rd !== 32'h1234AB78) begin n_fail++; $display("FAIL rst_ready_no_write got=%h exp=1234ab78", rd); end
    endtask

    task automatic test_random();
        int s, off, hi, r; logic sr, ae, aen, eae, wd; logic [31:0] rde, rd, a, d, old; logic [3:0] w;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) begin
                a = 32'h200 + 32'(4 * i);
                d = $urandom;
                access(k, 4'hF, a, d, 1'b0, s, sr, rde, rd, ae, aen);
                model_access(k, 4'hF, a, d, 1'b0, eae);
            end
            for (int n = 0; n < 40; n++) begin
                r   = $urandom_range(0, 9);
                off = $urandom_range(0, 7);
                a   = 32'h200 + 32'(4 * off);
                if (r == 0) begin
                    hi = $urandom_range(1, 16383);
                    a  = a | (32'(hi) << 18);
                end
                w  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                d  = $urandom;
                wd = (wait_of(k) > 0) && ($urandom_range(0, 7) == 0);
                old = exp_rd[k];
                access(k, w, a, d, wd, s, sr, rde, rd, ae, aen);
                model_access(k, w, a, d, wd, eae);
                n_checks++;
                if (s != wait_of(k)) begin n_fail++; $display("FAIL rand_stall inst=%0d n=%0d got=%0d exp=%0d", k, n, s, wait_of(k)); end
                n_checks++;
                if (rde !== old) begin n_fail++; $display("FAIL rand_rdata_early inst=%0d n=%0d got=%h exp=%h", k, n, rde, old); end
                n_checks++;
                if (rd !== exp_rd[k]) begin n_fail++; $display("FAIL rand_rdata inst=%0d n=%0d addr=%h wen=%h got=%h exp=%h", k, n, a, w, rd, exp_rd[k]); end
                n_checks++;
                if (ae !== eae || aen !== 1'b0) begin n_fail++; $display("FAIL rand_addr_err inst=%0d n=%0d got=%b%b exp=%b0", k, n, ae, aen, eae); end
            end
        end
    endtask

    task automatic test_w0_no_stall();
        n_checks++;
        if (stall0_seen !== 1'b0) begin n_fail++; $display("FAIL w0_stall_seen got=%b exp=0", stall0_seen); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back_w0();
        test_wait3_read();
        test_wait2_write();
        test_back_to_back_wait();
        test_addr_err();
        test_reset_mid_access();
        test_random();
        test_w0_no_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
